// File: rtl/fir_coeff_loader.sv
// ---------------------------------------------------------------------------
// fir_coeff_loader
//
// Feeds the FIR top's coefficient RAM port. A load begins with a one-cycle
// iLoadStart carrying the tap count N. The loader then accepts N coefficient
// words over a valid/ready stream and writes them to addresses 0..N-1, one
// word per cycle. It zero-fills addresses N..P-1, where P is N rounded up to
// a multiple of PAD_MULT (capped at 64). It publishes N on oNumOfCoeff only
// after the whole range has been written.
//
// Handshake: a word transfers on a rising edge where iCoefValid && oCoefReady.
// oCoefReady is combinational from the state and accept count only, never
// from iCoefValid. iCoefData is only looked at on a transfer edge.
//
// Parameters
//   PAD_MULT  pad-to multiple, power of two 1..64 (1 = no padding)
//   TIMEOUT   consecutive stall cycles tolerated in LOAD before abort
//
// Ports
//   iClk12M           system clock
//   iRst              synchronous active-high reset
//   iLoadStart        start request (honoured only when idle)
//   iNumOfCoeff[5:0]  tap count N, sampled with iLoadStart
//   iCoefValid        coefficient word valid
//   iCoefData[15:0]   coefficient word (signed, passed through unchanged)
//   oCoefReady        loader accepts a word this cycle
//   oCoeffUpdateFlag  FIR coefficient-update flag, high for the whole load
//   oAddrRam[5:0]     FIR RAM address
//   oWrDtRam[15:0]    FIR RAM write data
//   oWrEn             oAddrRam/oWrDtRam carry a new write this cycle
//   oNumOfCoeff[5:0]  FIR tap count, updated on successful completion only
//   oBusy             a load is in progress
//   oDone             one-cycle pulse, load completed
//   oErr              one-cycle pulse, N==0 start or stall timeout
//   oState[2:0]       current FSM state, for debug visibility
// ---------------------------------------------------------------------------
module fir_coeff_loader #(
    parameter int PAD_MULT = 8,
    parameter int TIMEOUT  = 255
) (
    input  logic        iClk12M,
    input  logic        iRst,
    input  logic        iLoadStart,
    input  logic [5:0]  iNumOfCoeff,
    input  logic        iCoefValid,
    input  logic [15:0] iCoefData,
    output logic        oCoefReady,
    output logic        oCoeffUpdateFlag,
    output logic [5:0]  oAddrRam,
    output logic [15:0] oWrDtRam,
    output logic        oWrEn,
    output logic [5:0]  oNumOfCoeff,
    output logic        oBusy,
    output logic        oDone,
    output logic        oErr,
    output logic [2:0]  oState
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARM  = 3'd1,
        LOAD = 3'd2,
        PAD  = 3'd3,
        TAIL = 3'd4
    } state_t;

    localparam logic [6:0]  PadMask    = 7'(PAD_MULT - 1);
    localparam logic [15:0] StallLimit = 16'(TIMEOUT - 1);

    state_t      state, stateNext;
    logic [5:0]  numLat, numLatNext;       // latched N for the active load
    logic [6:0]  padEnd, padEndNext;       // P, one past the last padded address
    logic [6:0]  cnt, cntNext;             // accept count in LOAD, pad address in PAD
    logic [15:0] stallCnt, stallCntNext;   // consecutive non-accept cycles in LOAD

    logic        flagNext, wrEnNext, busyNext, doneNext, errNext;
    logic [5:0]  addrNext, numOutNext;
    logic [15:0] dataNext;

    logic [6:0]  padRound;
    logic [6:0]  padTarget;
    logic [6:0]  cntInc;
    logic        accept;

    // Round N up to the pad multiple. The 7-bit sum cannot overflow
    // (63 + 63 < 128), and the cap keeps the address range inside 64 entries.
    assign padRound  = ({1'b0, iNumOfCoeff} + PadMask) & ~PadMask;
    assign padTarget = (padRound > 7'd64) ? 7'd64 : padRound;

    assign cntInc     = cnt + 7'd1;
    assign oCoefReady = (state == LOAD) && (cnt < {1'b0, numLat});
    assign accept     = oCoefReady && iCoefValid;
    assign oState     = state;

    always_ff @(posedge iClk12M) begin
        if (iRst) begin
            state            <= IDLE;
            numLat           <= '0;
            padEnd           <= '0;
            cnt              <= '0;
            stallCnt         <= '0;
            oCoeffUpdateFlag <= 1'b0;
            oAddrRam         <= '0;
            oWrDtRam         <= '0;
            oWrEn            <= 1'b0;
            oNumOfCoeff      <= '0;
            oBusy            <= 1'b0;
            oDone            <= 1'b0;
            oErr             <= 1'b0;
        end else begin
            state            <= stateNext;
            numLat           <= numLatNext;
            padEnd           <= padEndNext;
            cnt              <= cntNext;
            stallCnt         <= stallCntNext;
            oCoeffUpdateFlag <= flagNext;
            oAddrRam         <= addrNext;
            oWrDtRam         <= dataNext;
            oWrEn            <= wrEnNext;
            oNumOfCoeff      <= numOutNext;
            oBusy            <= busyNext;
            oDone            <= doneNext;
            oErr             <= errNext;
        end
    end

    always_comb begin
        stateNext    = state;
        numLatNext   = numLat;
        padEndNext   = padEnd;
        cntNext      = cnt;
        stallCntNext = stallCnt;
        addrNext     = oAddrRam;
        dataNext     = oWrDtRam;
        wrEnNext     = 1'b0;
        numOutNext   = oNumOfCoeff;
        doneNext     = 1'b0;
        errNext      = 1'b0;

        unique case (state)
            IDLE: begin
                if (iLoadStart) begin
                    if (iNumOfCoeff != 6'd0) begin
                        stateNext    = ARM;
                        numLatNext   = iNumOfCoeff;
                        padEndNext   = padTarget;
                        cntNext      = '0;
                        stallCntNext = '0;
                        addrNext     = '0;
                        dataNext     = '0;
                    end else begin
                        errNext = 1'b1;
                    end
                end
            end

            ARM: begin
                stateNext = LOAD;
            end

            LOAD: begin
                if (accept) begin
                    addrNext     = cnt[5:0];
                    dataNext     = iCoefData;
                    wrEnNext     = 1'b1;
                    cntNext      = cntInc;
                    stallCntNext = '0;
                    if (cntInc == {1'b0, numLat}) begin
                        // cnt now equals N, which is the first pad address.
                        stateNext = (padEnd > {1'b0, numLat}) ? PAD : TAIL;
                    end
                end else if (stallCnt == StallLimit) begin
                    // Abort: drop the flag and clear the RAM port together
                    // so the FIR never sees a half-finished update as valid.
                    stateNext = IDLE;
                    errNext   = 1'b1;
                    addrNext  = '0;
                    dataNext  = '0;
                end else begin
                    stallCntNext = stallCnt + 16'd1;
                end
            end

            PAD: begin
                addrNext = cnt[5:0];
                dataNext = '0;
                wrEnNext = 1'b1;
                cntNext  = cntInc;
                if (cntInc == padEnd) begin
                    stateNext = TAIL;
                end
            end

            TAIL: begin
                stateNext  = IDLE;
                doneNext   = 1'b1;
                numOutNext = numLat;
            end

            default: begin
                stateNext = IDLE;
            end
        endcase

        // The flag follows the state register one-for-one. Because of that
        // it cannot drop between ARM and TAIL.
        flagNext = (stateNext != IDLE);
        busyNext = (stateNext != IDLE);
    end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// ---------------------------------------------------------------------------
// tb_fir_coeff_loader
//
// Directed and randomized loads against a timeline model. For each load the
// bench plans the cycle on which every word is offered. It then derives the
// expected cycle-by-cycle picture from the load rules:
//   - the ARM cycle;
//   - one LOAD cycle per offer or gap;
//   - each write one cycle after its accept;
//   - the zero-fill up to the rounded size;
//   - the one-cycle done or error pulse.
// ---------------------------------------------------------------------------
module tb_fir_coeff_loader;

    localparam int PM   = 8;
    localparam int TO   = 20;
    localparam int MAXC = 1024;

    logic        iClk12M = 1'b0;
    logic        iRst;
    logic        iLoadStart;
    logic [5:0]  iNumOfCoeff;
    logic        iCoefValid;
    logic [15:0] iCoefData;
    logic        oCoefReady;
    logic        oCoeffUpdateFlag;
    logic [5:0]  oAddrRam;
    logic [15:0] oWrDtRam;
    logic        oWrEn;
    logic [5:0]  oNumOfCoeff;
    logic        oBusy;
    logic        oDone;
    logic        oErr;
    logic [2:0]  oState;

    always #5 iClk12M = ~iClk12M;

    fir_coeff_loader #(.PAD_MULT(PM), .TIMEOUT(TO)) dut (
        .iClk12M          (iClk12M),
        .iRst             (iRst),
        .iLoadStart       (iLoadStart),
        .iNumOfCoeff      (iNumOfCoeff),
        .iCoefValid       (iCoefValid),
        .iCoefData        (iCoefData),
        .oCoefReady       (oCoefReady),
        .oCoeffUpdateFlag (oCoeffUpdateFlag),
        .oAddrRam         (oAddrRam),
        .oWrDtRam         (oWrDtRam),
        .oWrEn            (oWrEn),
        .oNumOfCoeff      (oNumOfCoeff),
        .oBusy            (oBusy),
        .oDone            (oDone),
        .oErr             (oErr),
        .oState           (oState)
    );

    int          nCompared   = 0;
    int          nMismatched = 0;
    logic [5:0]  numModel    = '0;
    logic [15:0] preset[$];

    // Expected per-cycle picture of one load, indexed from the ARM cycle.
    logic        eFlag [MAXC];
    logic        eReady[MAXC];
    logic        eWr   [MAXC];
    logic        eErr  [MAXC];
    logic        eDone [MAXC];
    logic        eChkAd[MAXC];
    logic [5:0]  eAddr [MAXC];
    logic [5:0]  eNum  [MAXC];
    logic [15:0] eData [MAXC];
    logic        vSched[MAXC];
    logic [15:0] dSched[MAXC];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // n: tap count; gapLo/gapHi: idle cycles before each offered word;
    // words: words offered (n completes, fewer stalls into a timeout unless
    // doRst); doRst: reset one cycle after the last offered word is written;
    // midStart: cycle at which a spurious N=3 start is pulsed (-1 = none).
    task automatic run_load(input string name, input int n, input int gapLo, input int gapHi,
                            input int words, input bit doRst, input int midStart);
        int   p, c, g, lastAcc, loadEnd, lastCyc, rstCyc, total, flagCnt;
        bit   complete, abort;
        int   accCyc[$];
        logic [5:0]  curA;
        logic [15:0] curD, w;

        complete = (words == n) && !doRst;
        abort    = !complete && !doRst;
        p = ((n + PM - 1) / PM) * PM;
        if (p > 64) p = 64;

        for (int i = 0; i < MAXC; i++) begin
            vSched[i] = 1'b0;
            dSched[i] = 16'($urandom);
            eFlag[i]  = 1'b0; eReady[i] = 1'b0; eWr[i]  = 1'b0;
            eErr[i]   = 1'b0; eDone[i]  = 1'b0; eChkAd[i] = 1'b1;
            eAddr[i]  = '0;   eData[i]  = '0;   eNum[i] = numModel;
        end

        // Plan offers: LOAD starts at cycle 1 and ready stays high until n accepts.
        c = 1;
        for (int i = 0; i < words; i++) begin
            g = $urandom_range(gapHi, gapLo);
            c += g;
            w = (i < preset.size()) ? preset[i] : 16'($urandom);
            accCyc.push_back(c);
            vSched[c] = 1'b1;
            dSched[c] = w;
            eWr[c + 1]   = 1'b1;
            eAddr[c + 1] = 6'(i);
            eData[c + 1] = w;
            c++;
        end
        preset.delete();
        vSched[0] = 1'($urandom_range(1, 0));   // offer during ARM: must be ignored
        lastAcc = (words > 0) ? accCyc[words - 1] : 0;

        rstCyc = -1;
        if (complete) begin
            loadEnd = lastAcc;
            lastCyc = loadEnd + 1 + (p - n);
            for (int j = 0; j < p - n; j++) begin
                eWr[loadEnd + 2 + j]   = 1'b1;
                eAddr[loadEnd + 2 + j] = 6'(n + j);
                eData[loadEnd + 2 + j] = '0;
            end
            for (int i = loadEnd + 1; i <= lastCyc; i++) vSched[i] = 1'($urandom_range(1, 0));
        end else if (abort) begin
            loadEnd = lastAcc + TO;
            lastCyc = loadEnd;
        end else begin
            rstCyc  = lastAcc + 1;
            loadEnd = rstCyc;
            lastCyc = rstCyc;
        end
        total = lastCyc + 3;
        if (midStart > lastCyc) midStart = -1;

        curA = '0; curD = '0;
        for (int i = 0; i < total; i++) begin
            if (i <= lastCyc) eFlag[i] = 1'b1;
            if (i >= 1 && i <= loadEnd) eReady[i] = 1'b1;
            if (eWr[i]) begin
                curA = eAddr[i]; curD = eData[i];
            end else begin
                eAddr[i] = curA; eData[i] = curD;
            end
            if (i > lastCyc) begin
                if (complete) eChkAd[i] = 1'b0;
                else begin eAddr[i] = '0; eData[i] = '0; end
                if (complete) eNum[i] = 6'(n);
                if (doRst)    eNum[i] = '0;
            end
        end
        if (complete) eDone[lastCyc + 1] = 1'b1;
        if (abort)    eErr[lastCyc + 1]  = 1'b1;

        // Start pulse, then walk the planned timeline.
        iNumOfCoeff = 6'(n);
        iLoadStart  = 1'b1;
        @(posedge iClk12M); #1;
        flagCnt = 0;
        for (int i = 0; i < total; i++) begin
            iLoadStart  = (i == midStart);
            iNumOfCoeff = (i == midStart) ? 6'd3 : 6'(n);
            iCoefValid  = vSched[i];
            iCoefData   = dSched[i];
            iRst        = doRst && (i == rstCyc);
            @(negedge iClk12M);
            if (oCoeffUpdateFlag === 1'b1) flagCnt++;
            chk($sformatf("%s c%0d flag", name, i), oCoeffUpdateFlag, eFlag[i]);
            chk($sformatf("%s c%0d busy", name, i), oBusy, eFlag[i]);
            chk($sformatf("%s c%0d ready", name, i), oCoefReady, eReady[i]);
            chk($sformatf("%s c%0d wren", name, i), oWrEn, eWr[i]);
            chk($sformatf("%s c%0d err", name, i), oErr, eErr[i]);
            chk($sformatf("%s c%0d done", name, i), oDone, eDone[i]);
            chk($sformatf("%s c%0d num", name, i), oNumOfCoeff, eNum[i]);
            if (eChkAd[i]) begin
                chk($sformatf("%s c%0d addr", name, i), oAddrRam, eAddr[i]);
                chk($sformatf("%s c%0d data", name, i), oWrDtRam, eData[i]);
            end
            @(posedge iClk12M); #1;
        end
        iLoadStart = 1'b0; iRst = 1'b0; iCoefValid = 1'b0;
        chk($sformatf("%s flag-high cycles", name), flagCnt, lastCyc + 1);
        numModel = eNum[total - 1];
    endtask

    initial begin
        int n, k;
        iRst = 1'b1; iLoadStart = 1'b0; iNumOfCoeff = '0; iCoefValid = 1'b0; iCoefData = '0;
        repeat (3) @(posedge iClk12M);
        #1;
        iLoadStart = 1'b1; iNumOfCoeff = 6'd9; iCoefValid = 1'b1;   // reset must win
        @(negedge iClk12M);
        chk("reset flag", oCoeffUpdateFlag, 1'b0);
        chk("reset wren", oWrEn, 1'b0);
        chk("reset addr", oAddrRam, 6'd0);
        chk("reset data", oWrDtRam, 16'd0);
        chk("reset num", oNumOfCoeff, 6'd0);
        chk("reset busy/done/err", {oBusy, oDone, oErr}, 3'b000);
        chk("reset ready", oCoefReady, 1'b0);
        chk("reset state", oState, 3'd0);
        @(posedge iClk12M); #1;
        iRst = 1'b0; iLoadStart = 1'b0; iCoefValid = 1'b0;

        // N==0 start: error pulse, flag stays low.
        iNumOfCoeff = 6'd0; iLoadStart = 1'b1;
        @(posedge iClk12M); #1;
        iLoadStart = 1'b0;
        @(negedge iClk12M);
        chk("n0 err", oErr, 1'b1);
        chk("n0 flag", oCoeffUpdateFlag, 1'b0);
        chk("n0 busy", oBusy, 1'b0);
        @(posedge iClk12M); #1;
        @(negedge iClk12M);
        chk("n0 err clear", oErr, 1'b0);
        chk("n0 flag after", oCoeffUpdateFlag, 1'b0);
        @(posedge iClk12M); #1;

        preset.push_back(16'd13); preset.push_back(16'd0); preset.push_back(16'hFFED);
        run_load("T1", 21, 0, 0, 21, 1'b0, -1);
        run_load("T2", 5, 3, 3, 5, 1'b0, -1);
        run_load("T3", 16, 0, 2, 16, 1'b0, 8);
        run_load("T4", 10, 0, 0, 4, 1'b0, -1);
        run_load("T5rst", 21, 0, 1, 7, 1'b1, -1);
        run_load("T5re", 21, 0, 0, 21, 1'b0, -1);
        run_load("N63", 63, 0, 1, 63, 1'b0, -1);
        run_load("N1", 1, 0, 2, 1, 1'b0, -1);
        run_load("N8", 8, 0, 1, 8, 1'b0, 3);
        run_load("T0words", 6, 0, 0, 0, 1'b0, -1);

        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(63, 1);
            run_load($sformatf("rnd%0d", r), n, 0, 3, n, 1'b0, $urandom_range(40, 1));
        end
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(63, 2);
            k = $urandom_range(n - 1, 0);
            run_load($sformatf("rndabort%0d", r), n, 0, 3, k, 1'b0, -1);
            n = $urandom_range(63, 1);
            run_load($sformatf("rndafter%0d", r), n, 0, 2, n, 1'b0, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
